fifo_ram_ctrl: RTL

//  Pointer/flag controller that turns a push/pop stream interface into the write/read

---
 rtl/fifo_ram_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_ram_ctrl.sv
// Pointer and flag controller that pairs with a 16x8 dual-port RAM to form a synchronous FIFO.
// Drives the RAM write/read port controls each cycle; RAM data paths bypass this block.
module fifo_ram_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            rd_valid_q, overflow_q, underflow_q;
    logic            full, empty, push_ok, pop_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= pop_ok;
            overflow_q  <= push_i & full;
            underflow_q <= pop_i & empty;
        end
    end

    assign wr_en_o        = push_ok;
    assign wr_addr_o      = wr_ptr_q[ADDR_W-1:0];
    assign rd_en_o        = pop_ok;
    assign rd_addr_o      = rd_ptr_q[ADDR_W-1:0];
    assign rd_valid_o     = rd_valid_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AF_LVL);
    assign almost_empty_o = (count_q <= AE_LVL);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule
